// File: rtl/pl_pkg.sv
// pl_pkg: shared definitions for the RV32 pipeline stage registers.
//   - default payload/control widths
//   - stage-buffer state encoding (EMPTY / ONE / TWO)
//   - bit positions of the decoded control fields carried in ctrl
package pl_pkg;

    localparam int PL_DATA_W = 96;
    localparam int PL_CTRL_W = 12;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b10;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } pl_state_e;

    // Control field layout. An all-zero control word is a bubble:
    // RegWrite and MemWrite are both inactive.
    localparam int CTRL_REGWRITE = 0;  // 1 bit
    localparam int CTRL_MEMWRITE = 1;  // 1 bit
    localparam int CTRL_RESSRC   = 2;  // 2 bits [3:2]
    localparam int CTRL_FUNCT3   = 4;  // 3 bits [6:4]

endpackage

// File: rtl/pl_stage_slot.sv
// pl_stage_slot: one valid/ctrl/data holding register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture d_ctrl/d_data and set valid
//   clear           drop the entry: valid and ctrl go to 0, data is held
//   d_ctrl, d_data  values captured on load
//   valid, ctrl, data  registered entry contents
// clear wins over load so a squash can never be undone by a same-cycle load.
module pl_stage_slot
    import pl_pkg::*;
#(
    parameter int CTRL_W = PL_CTRL_W,
    parameter int DATA_W = PL_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pl_stage_buf.sv
// pl_stage_buf: parametrised pipeline stage register with valid/ready
// handshake, synchronous flush and optional two-entry skid buffer.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   flush_i                    synchronous squash of all held entries
//   in_valid/in_ready          upstream handshake
//   in_ctrl/in_data            upstream beat
//   out_valid/out_ready        downstream handshake
//   out_ctrl/out_data          downstream beat (ctrl is 0 when out_valid=0)
//   stall_cnt                  saturating count of out_valid && !out_ready cycles
//   dbg_state                  current occupancy state (EMPTY/ONE/TWO)
//
// Handshake: a beat moves on a rising edge where valid && ready are both 1.
// A producer holding valid=1 keeps its beat stable until it moves; ready may
// change freely while valid is low. With SKID=1 in_ready is a flop and never
// depends on out_ready; with SKID=0 it is combinational from out_ready.
module pl_stage_buf
    import pl_pkg::*;
#(
    parameter int DATA_W = PL_DATA_W,
    parameter int CTRL_W = PL_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);

    logic in_xfer;
    logic out_xfer;
    logic main_valid;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = main_valid && out_ready;
    assign out_valid = main_valid;

    generate
        if (SKID != 0) begin : g_skid
            pl_state_e         state;
            logic              rdy_q;
            logic              main_load, main_clr;
            logic              skid_load, skid_clr;
            logic [CTRL_W-1:0] main_d_ctrl;
            logic [DATA_W-1:0] main_d_data;
            logic              skid_valid;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            // Slot controls. The main slot loads from the input normally and
            // from the skid slot when draining TWO -> ONE.
            always_comb begin
                main_load   = 1'b0;
                main_clr    = 1'b0;
                skid_load   = 1'b0;
                skid_clr    = 1'b0;
                main_d_ctrl = in_ctrl;
                main_d_data = in_data;
                if (flush_i) begin
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end else begin
                    case (state)
                        S_EMPTY: begin
                            main_load = in_xfer;
                        end
                        S_ONE: begin
                            if (in_xfer && out_xfer) main_load = 1'b1;
                            else if (in_xfer)        skid_load = 1'b1;
                            else if (out_xfer)       main_clr  = 1'b1;
                        end
                        S_TWO: begin
                            if (out_xfer && skid_valid) begin
                                main_load   = 1'b1;
                                main_d_ctrl = skid_ctrl;
                                main_d_data = skid_data;
                                skid_clr    = 1'b1;
                            end
                        end
                        default: begin
                            main_clr = 1'b1;
                            skid_clr = 1'b1;
                        end
                    endcase
                end
            end

            // Occupancy FSM; in_ready is registered alongside the state.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= S_EMPTY;
                    rdy_q <= 1'b1;
                end else if (flush_i) begin
                    state <= S_EMPTY;
                    rdy_q <= 1'b1;
                end else begin
                    case (state)
                        S_EMPTY: begin
                            if (in_xfer) state <= S_ONE;
                        end
                        S_ONE: begin
                            if (in_xfer && !out_xfer) begin
                                state <= S_TWO;
                                rdy_q <= 1'b0;
                            end else if (!in_xfer && out_xfer) begin
                                state <= S_EMPTY;
                            end
                        end
                        S_TWO: begin
                            if (out_xfer) begin
                                state <= S_ONE;
                                rdy_q <= 1'b1;
                            end
                        end
                        default: begin
                            state <= S_EMPTY;
                            rdy_q <= 1'b1;
                        end
                    endcase
                end
            end

            assign in_ready  = rdy_q;
            assign dbg_state = state;

            pl_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk    (clk),
                .rst    (rst),
                .load   (main_load),
                .clear  (main_clr),
                .d_ctrl (main_d_ctrl),
                .d_data (main_d_data),
                .valid  (main_valid),
                .ctrl   (out_ctrl),
                .data   (out_data)
            );

            pl_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .load   (skid_load),
                .clear  (skid_clr),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .valid  (skid_valid),
                .ctrl   (skid_ctrl),
                .data   (skid_data)
            );
        end else begin : g_direct
            logic main_clr;

            // Flush blocks acceptance here, so a squashed cycle never loads.
            assign in_ready  = (!main_valid || out_ready) && !flush_i;
            assign main_clr  = flush_i || (out_xfer && !in_xfer);
            assign dbg_state = main_valid ? ST_ONE : ST_EMPTY;

            pl_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
                .clk    (clk),
                .rst    (rst),
                .load   (in_xfer),
                .clear  (main_clr),
                .d_ctrl (in_ctrl),
                .d_data (in_data),
                .valid  (main_valid),
                .ctrl   (out_ctrl),
                .data   (out_data)
            );
        end
    endgenerate

    // Back-pressure counter; only rst clears it so flushes do not lose history.
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pl_stage_buf.sv
// Directed bench for pl_stage_buf: a SKID=1 instance (s_*), a SKID=0
// instance (n_*) and a SKID=1, CNT_W=4 instance (c_*) for saturation and
// asynchronous reset.
module tb_pl_stage_buf;
    localparam int DW = 32;
    localparam int CW = 12;

    logic clk;
    logic rst;
    logic c_rst;

    logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [CW-1:0] s_in_ctrl, s_out_ctrl;
    logic [DW-1:0] s_in_data, s_out_data;
    logic [15:0]   s_stall;
    logic [1:0]    s_state;

    logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [CW-1:0] n_in_ctrl, n_out_ctrl;
    logic [DW-1:0] n_in_data, n_out_data;
    logic [15:0]   n_stall;
    logic [1:0]    n_state;

    logic          c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [CW-1:0] c_in_ctrl, c_out_ctrl;
    logic [DW-1:0] c_in_data, c_out_data;
    logic [3:0]    c_stall;
    logic [1:0]    c_state;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pl_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_s (
        .clk(clk), .rst(rst), .flush_i(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_ctrl(s_in_ctrl), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .stall_cnt(s_stall), .dbg_state(s_state)
    );

    pl_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_n (
        .clk(clk), .rst(rst), .flush_i(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_ctrl(n_in_ctrl), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_ctrl(n_out_ctrl), .out_data(n_out_data),
        .stall_cnt(n_stall), .dbg_state(n_state)
    );

    pl_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(c_rst), .flush_i(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ctrl(c_in_ctrl), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_ctrl(c_out_ctrl), .out_data(c_out_data),
        .stall_cnt(c_stall), .dbg_state(c_state)
    );

    // driver: advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_s_out_valid: got %0b expected 0", s_out_valid); end
        checks++;
        if (s_out_ctrl !== 12'h000) begin errors++; $display("FAIL rst_s_out_ctrl: got %0h expected 0", s_out_ctrl); end
        checks++;
        if (s_out_data !== 32'h0) begin errors++; $display("FAIL rst_s_out_data: got %0h expected 0", s_out_data); end
        checks++;
        if (s_stall !== 16'd0) begin errors++; $display("FAIL rst_s_stall: got %0d expected 0", s_stall); end
        checks++;
        if (s_in_ready !== 1'b1) begin errors++; $display("FAIL rst_s_in_ready: got %0b expected 1", s_in_ready); end
        checks++;
        if (s_state !== 2'b00) begin errors++; $display("FAIL rst_s_state: got %0d expected 0", s_state); end
        checks++;
        if (n_in_ready !== 1'b1) begin errors++; $display("FAIL rst_n_in_ready: got %0b expected 1", n_in_ready); end
        checks++;
        if (c_out_valid !== 1'b0) begin errors++; $display("FAIL rst_c_out_valid: got %0b expected 0", c_out_valid); end
        checks++;
        #9;
        rst   = 1'b0;
        c_rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ed = 32'h11 * (i + 1);
            ec = 12'h100 + 12'(i);
            s_in_valid = 1'b1;
            s_in_data  = ed;
            s_in_ctrl  = ec;
            step();
            if (s_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b expected 1", i, s_out_valid); end
            checks++;
            if (s_out_data !== ed) begin errors++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, s_out_data, ed); end
            checks++;
            if (s_out_ctrl !== ec) begin errors++; $display("FAIL b2b_ctrl[%0d]: got %0h expected %0h", i, s_out_ctrl, ec); end
            checks++;
            if (s_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %0b expected 1", i, s_in_ready); end
            checks++;
        end
        s_in_valid = 1'b0;
        step();
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid: got %0b expected 0", s_out_valid); end
        checks++;
        if (s_out_ctrl !== 12'h000) begin errors++; $display("FAIL b2b_drain_ctrl: got %0h expected 0", s_out_ctrl); end
        checks++;
        if (s_stall !== 16'd0) begin errors++; $display("FAIL b2b_stall: got %0d expected 0", s_stall); end
        checks++;
    endtask

    task automatic test_backpressure();
        logic drop;
        exp_q = {};
        exp_q.push_back(32'hA1);
        exp_q.push_back(32'hA2);
        exp_q.push_back(32'hA3);
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hA1;
        s_in_ctrl   = 12'h0A1;
        step();
        s_in_data = 32'hA2;
        s_in_ctrl = 12'h0A2;
        step();
        if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_two: got %0b expected 0", s_in_ready); end
        checks++;
        if (s_state !== 2'b10) begin errors++; $display("FAIL bp_state_two: got %0d expected 2", s_state); end
        checks++;
        s_in_data = 32'hA3;
        s_in_ctrl = 12'h0A3;
        step();
        if (s_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold: got %0b expected 0", s_in_ready); end
        checks++;
        if (s_out_data !== 32'hA1) begin errors++; $display("FAIL bp_head_data: got %0h expected a1", s_out_data); end
        checks++;
        if (s_stall !== 16'd2) begin errors++; $display("FAIL bp_stall_mid: got %0d expected 2", s_stall); end
        checks++;
        // drain: scoreboard pops each delivered beat in order
        s_out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            #1;
            drop = s_in_valid && s_in_ready;
            if (s_out_valid) begin
                if (s_out_data !== exp_q[0]) begin errors++; $display("FAIL bp_order: got %0h expected %0h", s_out_data, exp_q[0]); end
                checks++;
                void'(exp_q.pop_front());
            end
            step();
            if (drop) s_in_valid = 1'b0;
        end
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_missing: got %0d left expected 0", exp_q.size()); end
        checks++;
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %0b expected 0", s_out_valid); end
        checks++;
        if (s_stall !== 16'd2) begin errors++; $display("FAIL bp_stall_end: got %0d expected 2", s_stall); end
        checks++;
    endtask

    task automatic test_flush_two();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_ctrl   = 12'h0FF;
        s_in_data   = 32'hB1;
        step();
        s_in_data = 32'hB2;
        step();
        s_in_valid = 1'b0;
        if (s_state !== 2'b10) begin errors++; $display("FAIL fl_pre_state: got %0d expected 2", s_state); end
        checks++;
        if (s_out_ctrl !== 12'h0FF) begin errors++; $display("FAIL fl_pre_ctrl: got %0h expected ff", s_out_ctrl); end
        checks++;
        if (s_stall !== 16'd3) begin errors++; $display("FAIL fl_pre_stall: got %0d expected 3", s_stall); end
        checks++;
        s_flush     = 1'b1;
        s_out_ready = 1'b1;
        step();
        s_flush     = 1'b0;
        s_out_ready = 1'b0;
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %0b expected 0", s_out_valid); end
        checks++;
        if (s_out_ctrl !== 12'h000) begin errors++; $display("FAIL fl_ctrl: got %0h expected 0", s_out_ctrl); end
        checks++;
        if (s_in_ready !== 1'b1) begin errors++; $display("FAIL fl_in_ready: got %0b expected 1", s_in_ready); end
        checks++;
        if (s_state !== 2'b00) begin errors++; $display("FAIL fl_state: got %0d expected 0", s_state); end
        checks++;
        if (s_stall !== 16'd3) begin errors++; $display("FAIL fl_stall: got %0d expected 3", s_stall); end
        checks++;
        if (s_out_data !== 32'hB1) begin errors++; $display("FAIL fl_data_held: got %0h expected b1", s_out_data); end
        checks++;
        step();
        if (s_out_valid !== 1'b0) begin errors++; $display("FAIL fl_skid_gone: got %0b expected 0", s_out_valid); end
        checks++;
    endtask

    task automatic test_skid0_passthru();
        n_out_ready = 1'b1;
        n_in_valid  = 1'b1;
        n_in_data   = 32'hC1;
        n_in_ctrl   = 12'h021;
        #1;
        if (n_in_ready !== 1'b1) begin errors++; $display("FAIL s0_ready_empty: got %0b expected 1", n_in_ready); end
        checks++;
        step();
        n_in_data = 32'hC2;
        n_in_ctrl = 12'h022;
        #1;
        if (n_in_ready !== 1'b1) begin errors++; $display("FAIL s0_ready_full_rdy: got %0b expected 1", n_in_ready); end
        checks++;
        step();
        if (n_out_valid !== 1'b1) begin errors++; $display("FAIL s0_no_bubble: got %0b expected 1", n_out_valid); end
        checks++;
        if (n_out_data !== 32'hC2) begin errors++; $display("FAIL s0_data: got %0h expected c2", n_out_data); end
        checks++;
        n_out_ready = 1'b0;
        n_in_data   = 32'hC3;
        n_in_ctrl   = 12'h023;
        #1;
        if (n_in_ready !== 1'b0) begin errors++; $display("FAIL s0_ready_bp: got %0b expected 0", n_in_ready); end
        checks++;
        step();
        if (n_out_data !== 32'hC2) begin errors++; $display("FAIL s0_hold: got %0h expected c2", n_out_data); end
        checks++;
        if (n_stall !== 16'd1) begin errors++; $display("FAIL s0_stall: got %0d expected 1", n_stall); end
        checks++;
        n_out_ready = 1'b1;
        n_flush     = 1'b1;
        #1;
        if (n_in_ready !== 1'b0) begin errors++; $display("FAIL s0_ready_flush: got %0b expected 0", n_in_ready); end
        checks++;
        step();
        n_flush    = 1'b0;
        n_in_valid = 1'b0;
        if (n_out_valid !== 1'b0) begin errors++; $display("FAIL s0_flush_valid: got %0b expected 0", n_out_valid); end
        checks++;
        if (n_out_ctrl !== 12'h000) begin errors++; $display("FAIL s0_flush_ctrl: got %0h expected 0", n_out_ctrl); end
        checks++;
    endtask

    task automatic test_saturate_async_rst();
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        c_in_data   = 32'hD1;
        c_in_ctrl   = 12'h003;
        step();
        c_in_valid = 1'b0;
        if (c_stall !== 4'd0) begin errors++; $display("FAIL sat_start: got %0d expected 0", c_stall); end
        checks++;
        repeat (20) step();
        if (c_stall !== 4'd15) begin errors++; $display("FAIL sat_value: got %0d expected 15", c_stall); end
        checks++;
        if (c_out_data !== 32'hD1) begin errors++; $display("FAIL sat_data: got %0h expected d1", c_out_data); end
        checks++;
        #2;
        c_rst = 1'b1;
        #1;
        if (c_out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b expected 0", c_out_valid); end
        checks++;
        if (c_out_ctrl !== 12'h000) begin errors++; $display("FAIL arst_ctrl: got %0h expected 0", c_out_ctrl); end
        checks++;
        if (c_stall !== 4'd0) begin errors++; $display("FAIL arst_stall: got %0d expected 0", c_stall); end
        checks++;
        #3;
        c_rst = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; c_rst = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_ctrl = '0; s_in_data = '0;
        n_flush = 1'b0; n_in_valid = 1'b0; n_out_ready = 1'b0; n_in_ctrl = '0; n_in_data = '0;
        c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_ctrl = '0; c_in_data = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_flush_two();
        test_skid0_passthru();
        test_saturate_async_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
